// File: rtl/axis_hdr_strip_pkg.sv
// Shared types and helpers for the market-data ingress header stripper.
// The geometry constants describe the default build; modules derive their own from parameters.
package parser_pkg;

    typedef enum logic [1:0] {HDR, BODY, FLUSH} state_t;

    localparam int unsigned MAX_BYTES     = 128;
    localparam int unsigned IDX_W         = $clog2(MAX_BYTES);
    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_HDR_BYTES = 42;
    localparam int unsigned BYTES         = DEF_DATA_W / 8;
    localparam int unsigned SKIP_BEATS    = DEF_HDR_BYTES / BYTES;
    localparam int unsigned SHIFT         = DEF_HDR_BYTES % BYTES;

    // keep[nbytes-1] is lane 0; counting stops at the first cleared lane
    function automatic int unsigned lead_ones(input logic [MAX_BYTES-1:0] keep,
                                              input int unsigned nbytes);
        int unsigned n   = 0;
        logic        run = 1'b1;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes && run) begin
                if (keep[IDX_W'(nbytes - 1 - i)]) n++;
                else                             run = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned cnt,
                                                       input int unsigned nbytes);
        logic [MAX_BYTES-1:0] m = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < cnt && i < nbytes) m[IDX_W'(nbytes - 1 - i)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_hdr_strip_reg_slice.sv
// Single-entry AXI-Stream output register; contents hold while valid and not accepted.
module axis_reg_slice #(
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic [DATA_W/8-1:0] in_keep_i,
    input  logic                in_last_i,
    output logic                in_ready_o,
    output logic                out_valid_o,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [DATA_W/8-1:0] out_keep_o,
    output logic                out_last_o,
    input  logic                out_ready_i
);

    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] keep_q;
    logic                last_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_last_o  = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            keep_q  <= in_keep_i;
            last_q  <= in_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_hdr_strip.sv
// Strips HDR_BYTES leading bytes from each AXI-Stream frame and repacks the payload
// into full MSB-first beats, dropping frames with no payload.
module axis_hdr_strip #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned HDR_BYTES = 42,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tvalid,
    input  logic                s_tlast,
    output logic                s_tready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tvalid,
    output logic                m_tlast,
    input  logic                m_tready,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    runt_cnt
);
    import parser_pkg::*;

    localparam int unsigned LANES    = DATA_W / 8;
    localparam int unsigned LANE_OFS = HDR_BYTES % LANES;
    localparam int unsigned HCW      = $clog2(HDR_BYTES + LANES + 1);
    localparam int unsigned CW       = $clog2(LANES + 1);

    state_t                 state_q, state_d;
    logic [HCW-1:0]         hcnt_q, hcnt_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic [CW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d, runt_cnt_q, runt_cnt_d;

    logic                   ld_valid, ld_last, ld_ready, accept;
    logic [DATA_W-1:0]      ld_data, new_m, new_al;
    logic [LANES-1:0]       ld_keep, kbits;
    logic [2*DATA_W-1:0]    cat;
    logic [MAX_BYTES-1:0]   kmask_in, kmask_out;
    int unsigned            k_in, off, n, h, t;

    always_comb begin
        k_in     = s_tlast ? lead_ones(MAX_BYTES'(s_tkeep), LANES) : LANES;
        kmask_in = keep_mask(k_in, LANES);
    end
    assign kbits = kmask_in[LANES-1:0];

    for (genvar j = 0; j < LANES; j++) begin : g_mask
        assign new_m[DATA_W-1-8*j -: 8] = kbits[LANES-1-j] ? s_tdata[DATA_W-1-8*j -: 8] : 8'h00;
    end

    assign s_tready  = ld_ready && (state_q != FLUSH);
    assign accept    = s_tvalid && s_tready;
    assign frame_cnt = frame_cnt_q;
    assign runt_cnt  = runt_cnt_q;

    // Held bytes sit MSB-aligned in hold_q; the new beat is appended right after them,
    // top half of cat is the next output beat and the bottom half the leftover.
    always_comb begin
        off    = (state_q == HDR) ? LANE_OFS : 32'd0;
        h      = 32'(hold_cnt_q);
        n      = (k_in > off) ? k_in - off : 32'd0;
        t      = h + n;
        new_al = new_m << (off * 8);
        cat    = {hold_q, {DATA_W{1'b0}}} | ({new_al, {DATA_W{1'b0}}} >> (h * 8));

        state_d     = state_q;
        hcnt_d      = hcnt_q;
        hold_d      = hold_q;
        hold_cnt_d  = hold_cnt_q;
        frame_cnt_d = frame_cnt_q;
        runt_cnt_d  = runt_cnt_q;
        ld_valid    = 1'b0;
        ld_data     = cat[2*DATA_W-1:DATA_W];
        ld_last     = 1'b0;
        kmask_out   = keep_mask(LANES, LANES);

        case (state_q)
            HDR: if (accept) begin
                if (32'(hcnt_q) + k_in > HDR_BYTES) begin
                    hcnt_d = '0;
                    if (s_tlast) begin
                        ld_valid  = 1'b1;
                        ld_last   = 1'b1;
                        kmask_out = keep_mask(t, LANES);
                        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end else if (t >= LANES) begin
                        ld_valid   = 1'b1;
                        hold_d     = cat[DATA_W-1:0];
                        hold_cnt_d = CW'(t - LANES);
                        state_d    = BODY;
                    end else begin
                        hold_d     = cat[2*DATA_W-1:DATA_W];
                        hold_cnt_d = CW'(t);
                        state_d    = BODY;
                    end
                end else if (s_tlast) begin
                    hcnt_d = '0;
                    if (runt_cnt_q != '1) runt_cnt_d = runt_cnt_q + CNT_W'(1);
                end else begin
                    hcnt_d = HCW'(32'(hcnt_q) + LANES);
                end
            end
            BODY: if (accept) begin
                ld_valid = 1'b1;
                if (s_tlast && t <= LANES) begin
                    ld_last    = 1'b1;
                    kmask_out  = keep_mask(t, LANES);
                    hold_d     = '0;
                    hold_cnt_d = '0;
                    state_d    = HDR;
                    if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end else begin
                    hold_d     = cat[DATA_W-1:0];
                    hold_cnt_d = CW'(t - LANES);
                    if (s_tlast) state_d = FLUSH;
                end
            end
            FLUSH: begin
                ld_valid  = 1'b1;
                ld_data   = hold_q;
                ld_last   = 1'b1;
                kmask_out = keep_mask(h, LANES);
                if (ld_ready) begin
                    hold_d     = '0;
                    hold_cnt_d = '0;
                    state_d    = HDR;
                    if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = HDR;
        endcase
        ld_keep = kmask_out[LANES-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            hcnt_q      <= '0;
            hold_q      <= '0;
            hold_cnt_q  <= '0;
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end

    axis_reg_slice #(.DATA_W(DATA_W)) u_out (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (ld_valid),
        .in_data_i   (ld_data),
        .in_keep_i   (ld_keep),
        .in_last_i   (ld_last),
        .in_ready_o  (ld_ready),
        .out_valid_o (m_tvalid),
        .out_data_o  (m_tdata),
        .out_keep_o  (m_tkeep),
        .out_last_o  (m_tlast),
        .out_ready_i (m_tready)
    );

endmodule

// File: tb/tb_axis_hdr_strip.sv
// Self-checking bench for axis_hdr_strip: directed table, reset-mid-frame sequence and
// randomized frames checked against a byte-queue payload model.
module tb_axis_hdr_strip;

    localparam int DW = 64;
    localparam int NB = 8;
    localparam int HB = 42;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [NB-1:0] s_tkeep;
    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic [NB-1:0] m_tkeep;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b1;
    logic [15:0]   frame_cnt, runt_cnt;

    always #5 clk = ~clk;

    axis_hdr_strip #(.DATA_W(DW), .HDR_BYTES(HB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .frame_cnt(frame_cnt), .runt_cnt(runt_cnt)
    );

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;
    int exp_runts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // downstream ready pattern: 0 always, 1 toggling starting high, 2 random
    int rdy_mode = 0;
    bit tog = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       begin tog = ~tog; m_tready = tog; end
            2:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b1;
        endcase
    end

    logic [63:0] got_d[$];
    logic [7:0]  got_k[$];
    bit          got_l[$];
    bit          stalled = 1'b0;
    logic [63:0] st_d;
    logic [7:0]  st_k;
    logic        st_l;
    int          sready_low = 0;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) chk("stall_hold", {m_tdata[55:0], m_tkeep}, {st_d[55:0], st_k});
            if (stalled) chk("stall_hold_top", {m_tdata[63:56], 7'd0, m_tlast}, {st_d[63:56], 7'd0, st_l});
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_k.push_back(m_tkeep);
                got_l.push_back(m_tlast);
            end
            stalled = m_tvalid && !m_tready;
            st_d = m_tdata; st_k = m_tkeep; st_l = m_tlast;
            if (!s_tready) sready_low++;
        end
    end

    logic [7:0] frm[$];

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit l);
        int w = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        @(negedge clk);
        while (!s_tready && w < 200) begin w++; @(negedge clk); end
        if (!s_tready) chk("s_tready_timeout", 64'(s_tready), 64'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic make_beat(input int b, input bit rnd, output logic [63:0] d,
                             output logic [7:0] k, output bit l);
        int cnt = (frm.size() - b * NB > NB) ? NB : frm.size() - b * NB;
        d = '0; k = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < cnt) begin
                d[63-8*j -: 8] = frm[b*NB+j];
                k[7-j] = 1'b1;
            end else begin
                d[63-8*j -: 8] = 8'($urandom);
                if (rnd && j > cnt) k[7-j] = 1'($urandom);
            end
        end
        l = ((b + 1) * NB >= frm.size());
    endtask

    task automatic build_frame(input int n, input bit rnd);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    task automatic send_frame(input int n, input bit rnd, input bit gaps);
        logic [63:0] d;
        logic [7:0]  k;
        bit          l;
        build_frame(n, rnd);
        for (int b = 0; b * NB < n; b++) begin
            make_beat(b, rnd, d, k, l);
            if (gaps) while ($urandom_range(0, 3) == 0) begin s_tvalid = 1'b0; @(posedge clk); #1; end
            send_beat(d, k, l);
        end
    endtask

    task automatic drain(input int nb);
        int w = 0;
        while (got_d.size() < nb && w < 500) begin @(posedge clk); w++; end
        repeat (6) @(posedge clk);
        #1;
    endtask

    // payload = frame bytes from HB on, packed 8 per beat, last beat partial
    task automatic check_frame(input string tag);
        int p  = frm.size() - HB;
        int nb = (p > 0) ? (p + NB - 1) / NB : 0;
        drain(nb);
        if (p > 0) exp_frames++; else exp_runts++;
        chk({tag, " beats"}, 64'(got_d.size()), 64'(nb));
        for (int b = 0; b < nb; b++) begin
            logic [63:0] ed = '0;
            logic [63:0] km = '0;
            logic [7:0]  ek = '0;
            for (int j = 0; j < NB; j++) begin
                int idx = HB + b * NB + j;
                if (idx < frm.size()) begin
                    ed[63-8*j -: 8] = frm[idx];
                    km[63-8*j -: 8] = 8'hFF;
                    ek[7-j] = 1'b1;
                end
            end
            if (b < got_d.size()) begin
                chk($sformatf("%s data[%0d]", tag, b), got_d[b] & km, ed);
                chk($sformatf("%s keep[%0d]", tag, b), 64'(got_k[b]), 64'(ek));
                chk($sformatf("%s last[%0d]", tag, b), 64'(got_l[b]), 64'(b == nb - 1));
            end
        end
        chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
        chk({tag, " runt_cnt"}, 64'(runt_cnt), 64'(exp_runts));
        got_d.delete(); got_k.delete(); got_l.delete();
    endtask

    typedef struct {
        int          n;
        int          mode;
        int          beats;
        logic [7:0]  first_keep;
        logic [7:0]  last_keep;
        logic [63:0] first_data;
        int          sready_low;   // -1: not checked
    } vec_t;

    vec_t tbl[8];

    task automatic run_vec(input int i);
        vec_t v = tbl[i];
        logic [63:0] fm = '0;
        string tag = $sformatf("vec%0d_n%0d", i, v.n);
        rdy_mode = v.mode;
        @(posedge clk); #1;
        sready_low = 0;
        send_frame(v.n, 1'b0, 1'b0);
        drain(v.beats);
        for (int j = 0; j < NB; j++) if (v.first_keep[7-j]) fm[63-8*j -: 8] = 8'hFF;
        chk({tag, " nbeats"}, 64'(got_d.size()), 64'(v.beats));
        if (v.beats > 0 && got_d.size() > 0) begin
            chk({tag, " first_data"}, got_d[0] & fm, v.first_data);
            chk({tag, " first_keep"}, 64'(got_k[0]), 64'(v.first_keep));
            chk({tag, " last_keep"}, 64'(got_k[got_k.size()-1]), 64'(v.last_keep));
            chk({tag, " last_flag"}, 64'(got_l[got_l.size()-1]), 64'd1);
        end
        if (v.sready_low >= 0) chk({tag, " sready_low"}, 64'(sready_low), 64'(v.sready_low));
        check_frame(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  k;
        bit          l;

        tbl[0] = '{158, 0, 15, 8'hFF, 8'hF0, 64'h2A2B2C2D2E2F3031, 1};
        tbl[1] = '{158, 1, 15, 8'hFF, 8'hF0, 64'h2A2B2C2D2E2F3031, -1};
        tbl[2] = '{40,  0, 0,  8'h00, 8'h00, 64'h0, 0};
        tbl[3] = '{42,  0, 0,  8'h00, 8'h00, 64'h0, 0};
        tbl[4] = '{43,  0, 1,  8'h80, 8'h80, 64'h2A00000000000000, 0};
        tbl[5] = '{56,  0, 2,  8'hFF, 8'hFC, 64'h2A2B2C2D2E2F3031, 1};
        tbl[6] = '{48,  0, 1,  8'hFC, 8'hFC, 64'h2A2B2C2D2E2F0000, 0};
        tbl[7] = '{50,  0, 1,  8'hFF, 8'hFF, 64'h2A2B2C2D2E2F3031, 0};

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst m_tlast", 64'(m_tlast), 64'd0);
        chk("rst m_tdata", m_tdata, 64'd0);
        chk("rst m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst runt_cnt", 64'(runt_cnt), 64'd0);
        chk("rst s_tready", 64'(s_tready), 64'd1);

        for (int i = 0; i < 8; i++) run_vec(i);

        // reset while beat 10 of a frame is presented, then a clean frame
        rdy_mode = 0;
        @(posedge clk); #1;
        build_frame(158, 1'b0);
        for (int b = 0; b < 9; b++) begin
            make_beat(b, 1'b0, d, k, l);
            send_beat(d, k, l);
        end
        make_beat(9, 1'b0, d, k, l);
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_tvalid = 1'b0;
        got_d.delete(); got_k.delete(); got_l.delete();
        exp_frames = 0; exp_runts = 0;
        @(negedge clk);
        chk("midrst m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst frame_cnt", 64'(frame_cnt), 64'd0);
        chk("midrst runt_cnt", 64'(runt_cnt), 64'd0);
        chk("midrst s_tready", 64'(s_tready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst no_output", 64'(got_d.size()), 64'd0);
        send_frame(158, 1'b0, 1'b0);
        drain(15);
        if (got_d.size() > 0) chk("postrst first_data", got_d[0], 64'h2A2B2C2D2E2F3031);
        check_frame("postrst");

        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            send_frame($urandom_range(1, 130), 1'b1, 1'b1);
            check_frame($sformatf("rand%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
